// File: rtl/mindy_frame_builder_if.sv
// Bundle of the three streams around mindy_frame_builder.
//   AXIS_IN_*      raw data beats into the frame builder
//   AXIS_FD_OUT_*  registered frame-data beats out of the frame builder
//   AXIS_MD_OUT_*  one meta-data beat per completed frame
// Modport master is the frame-builder side (it masters the FD/MD streams and
// owns IN_TREADY); modport slave is the surrounding environment.
interface mindy_frame_builder_if #(
  parameter int DATA_WBITS = 512
);
  logic [DATA_WBITS-1:0] AXIS_IN_TDATA;
  logic                  AXIS_IN_TVALID;
  logic                  AXIS_IN_TREADY;
  logic [DATA_WBITS-1:0] AXIS_FD_OUT_TDATA;
  logic                  AXIS_FD_OUT_TVALID;
  logic                  AXIS_FD_OUT_TREADY;
  logic [DATA_WBITS-1:0] AXIS_MD_OUT_TDATA;
  logic                  AXIS_MD_OUT_TVALID;
  logic                  AXIS_MD_OUT_TREADY;

  modport master (
    input  AXIS_IN_TDATA, AXIS_IN_TVALID, AXIS_FD_OUT_TREADY, AXIS_MD_OUT_TREADY,
    output AXIS_IN_TREADY, AXIS_FD_OUT_TDATA, AXIS_FD_OUT_TVALID,
           AXIS_MD_OUT_TDATA, AXIS_MD_OUT_TVALID
  );

  modport slave (
    output AXIS_IN_TDATA, AXIS_IN_TVALID, AXIS_FD_OUT_TREADY, AXIS_MD_OUT_TREADY,
    input  AXIS_IN_TREADY, AXIS_FD_OUT_TDATA, AXIS_FD_OUT_TVALID,
           AXIS_MD_OUT_TDATA, AXIS_MD_OUT_TVALID
  );
endinterface

// File: rtl/mindy_frame_builder.sv
// mindy_frame_builder: slices a continuous raw beat stream into frames of
// FRAME_BEATS beats, forwards every beat through a single-entry FD register and
// emits one MD beat per completed frame carrying
//   [31:0] frame number, [63:32] start timestamp, [95:64] end timestamp.
// Ports:
//   clk          sole clock
//   reset        asynchronous, active-high
//   bus          mindy_frame_builder_if.master (IN / FD_OUT / MD_OUT streams)
//   frames_done  count of MD beats handed downstream, wraps at 32 bits
module mindy_frame_builder #(
  parameter int DATA_WBITS  = 512,
  parameter int FRAME_BEATS = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  mindy_frame_builder_if.master        bus,
  output logic [31:0]                  frames_done
);

  localparam int CNT_W = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1;

  logic [31:0]           ts;
  logic [CNT_W-1:0]      beat_cnt;
  logic [31:0]           frame_num;
  logic [31:0]           start_ts;

  logic [DATA_WBITS-1:0] fd_data_p1;
  logic                  fd_vld_p1;
  logic [DATA_WBITS-1:0] md_data_p1;
  logic                  md_vld_p1;

  logic                  fd_free;
  logic                  md_free;
  logic                  last_beat;
  logic                  first_beat;
  logic                  in_ready;
  logic                  in_hs;
  logic                  md_hs;
  logic [DATA_WBITS-1:0] md_word;

  assign fd_free    = !fd_vld_p1 || bus.AXIS_FD_OUT_TREADY;
  assign md_free    = !md_vld_p1 || bus.AXIS_MD_OUT_TREADY;
  assign last_beat  = (beat_cnt == CNT_W'(FRAME_BEATS - 1));
  assign first_beat = (beat_cnt == '0);
  // Only the last beat of a frame needs room in the MD register; earlier beats
  // keep flowing while a previous frame's MD beat waits downstream.
  assign in_ready   = !reset && fd_free && (!last_beat || md_free);
  assign in_hs      = in_ready && bus.AXIS_IN_TVALID;
  assign md_hs      = md_vld_p1 && bus.AXIS_MD_OUT_TREADY;

  // With a one-beat frame the start timestamp is captured in the same cycle
  // the MD word is built, so take the live counter instead of start_ts.
  always_comb begin
    md_word        = '0;
    md_word[31:0]  = frame_num;
    md_word[63:32] = first_beat ? ts : start_ts;
    md_word[95:64] = ts;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts <= '0;
    end else begin
      ts <= ts + 32'd1;
    end
  end

  // Stage p0 -> p1: frame position tracking and start timestamp capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_cnt <= '0;
      start_ts <= '0;
    end else if (in_hs) begin
      if (first_beat) start_ts <= ts;
      if (last_beat) beat_cnt <= '0;
      else           beat_cnt <= beat_cnt + 1'b1;
    end
  end

  // Stage p1: frame-data output register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fd_data_p1 <= '0;
      fd_vld_p1  <= 1'b0;
    end else if (in_hs) begin
      fd_data_p1 <= bus.AXIS_IN_TDATA;
      fd_vld_p1  <= 1'b1;
    end else if (bus.AXIS_FD_OUT_TREADY) begin
      fd_vld_p1  <= 1'b0;
    end
  end

  // Stage p1: meta-data output register; a new load wins over a drain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_data_p1 <= '0;
      md_vld_p1  <= 1'b0;
      frame_num  <= '0;
    end else if (in_hs && last_beat) begin
      md_data_p1 <= md_word;
      md_vld_p1  <= 1'b1;
      frame_num  <= frame_num + 32'd1;
    end else if (md_hs) begin
      md_vld_p1  <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frames_done <= '0;
    end else if (md_hs) begin
      frames_done <= frames_done + 32'd1;
    end
  end

  assign bus.AXIS_IN_TREADY     = in_ready;
  assign bus.AXIS_FD_OUT_TDATA  = fd_data_p1;
  assign bus.AXIS_FD_OUT_TVALID = fd_vld_p1;
  assign bus.AXIS_MD_OUT_TDATA  = md_data_p1;
  assign bus.AXIS_MD_OUT_TVALID = md_vld_p1;

endmodule

// File: tb/tb_mindy_frame_builder.sv
module tb_mindy_frame_builder;

  localparam int W  = 128;
  localparam int FB = 4;

  logic        clk;
  logic        reset;
  logic [31:0] done_a;
  logic [31:0] done_b;

  mindy_frame_builder_if #(.DATA_WBITS(W)) ifa ();
  mindy_frame_builder_if #(.DATA_WBITS(W)) ifb ();

  mindy_frame_builder #(.DATA_WBITS(W), .FRAME_BEATS(FB)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa), .frames_done(done_a)
  );

  mindy_frame_builder #(.DATA_WBITS(W), .FRAME_BEATS(1)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb), .frames_done(done_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [W-1:0] mk_md(input logic [31:0] f, input logic [31:0] s,
                                         input logic [31:0] e);
    logic [W-1:0] v;
    v        = '0;
    v[31:0]  = f;
    v[63:32] = s;
    v[95:64] = e;
    return v;
  endfunction

  function automatic logic [31:0] span(input logic [W-1:0] md);
    logic [31:0] s;
    logic [31:0] e;
    s = md[63:32];
    e = md[95:64];
    return e - s;
  endfunction

  // ---------------- reference model for dut_a ----------------
  logic [W-1:0] fd_q[$];
  logic [W-1:0] md_q[$];
  logic [W-1:0] fd_log[$];
  logic [W-1:0] md_log[$];
  int           fd_cyc[$];
  int           beat_m;
  logic [31:0]  fnum_m;
  logic [31:0]  fdone_m;
  logic [31:0]  ts_m;
  logic [31:0]  start_m;
  int           cyc = 0;
  bit           force_req = 0;

  always @(negedge clk) begin
    logic exp_rdy;
    if (force_req) begin
      fnum_m    = 32'hFFFF_FFFF;
      fdone_m   = 32'hFFFF_FFFF;
      force_req = 0;
    end
    if (reset) begin
      chk("rst_in_ready", W'(ifa.AXIS_IN_TREADY), W'(0));
      chk("rst_fd_valid", W'(ifa.AXIS_FD_OUT_TVALID), W'(0));
      chk("rst_md_valid", W'(ifa.AXIS_MD_OUT_TVALID), W'(0));
      chk("rst_fd_data", ifa.AXIS_FD_OUT_TDATA, W'(0));
      chk("rst_md_data", ifa.AXIS_MD_OUT_TDATA, W'(0));
      chk("rst_frames_done", W'(done_a), W'(0));
      fd_q.delete();
      md_q.delete();
      beat_m  = 0;
      fnum_m  = 0;
      fdone_m = 0;
      ts_m    = 0;
      start_m = 0;
    end else begin
      exp_rdy = (fd_q.size() == 0 || ifa.AXIS_FD_OUT_TREADY) &&
                (beat_m != FB - 1 || md_q.size() == 0 || ifa.AXIS_MD_OUT_TREADY);
      chk("in_ready", W'(ifa.AXIS_IN_TREADY), W'(exp_rdy));
      chk("fd_valid", W'(ifa.AXIS_FD_OUT_TVALID), W'(fd_q.size() != 0));
      if (fd_q.size() != 0) chk("fd_data", ifa.AXIS_FD_OUT_TDATA, fd_q[0]);
      chk("md_valid", W'(ifa.AXIS_MD_OUT_TVALID), W'(md_q.size() != 0));
      if (md_q.size() != 0) chk("md_data", ifa.AXIS_MD_OUT_TDATA, md_q[0]);
      chk("frames_done", W'(done_a), W'(fdone_m));

      if (ifa.AXIS_FD_OUT_TVALID && ifa.AXIS_FD_OUT_TREADY) begin
        fd_log.push_back(ifa.AXIS_FD_OUT_TDATA);
        fd_cyc.push_back(cyc);
      end
      if (ifa.AXIS_MD_OUT_TVALID && ifa.AXIS_MD_OUT_TREADY)
        md_log.push_back(ifa.AXIS_MD_OUT_TDATA);

      if (fd_q.size() != 0 && ifa.AXIS_FD_OUT_TREADY) void'(fd_q.pop_front());
      if (md_q.size() != 0 && ifa.AXIS_MD_OUT_TREADY) begin
        void'(md_q.pop_front());
        fdone_m = fdone_m + 32'd1;
      end
      if (exp_rdy && ifa.AXIS_IN_TVALID) begin
        fd_q.push_back(ifa.AXIS_IN_TDATA);
        if (beat_m == 0) start_m = ts_m;
        if (beat_m == FB - 1) begin
          md_q.push_back(mk_md(fnum_m, start_m, ts_m));
          fnum_m = fnum_m + 32'd1;
          beat_m = 0;
        end else begin
          beat_m++;
        end
      end
      ts_m = ts_m + 32'd1;
    end
    cyc++;
  end

  // ---------------- capture for dut_b (one-beat frames) ----------------
  logic [W-1:0] fdb_log[$];
  logic [W-1:0] mdb_log[$];

  always @(negedge clk) begin
    if (!reset) begin
      if (ifb.AXIS_FD_OUT_TVALID && ifb.AXIS_FD_OUT_TREADY) fdb_log.push_back(ifb.AXIS_FD_OUT_TDATA);
      if (ifb.AXIS_MD_OUT_TVALID && ifb.AXIS_MD_OUT_TREADY) mdb_log.push_back(ifb.AXIS_MD_OUT_TDATA);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic send_a(input logic [W-1:0] d);
    int n;
    n = 0;
    ifa.AXIS_IN_TDATA  = d;
    ifa.AXIS_IN_TVALID = 1'b1;
    @(negedge clk);
    while (!ifa.AXIS_IN_TREADY && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ifa.AXIS_IN_TREADY) chk("send_timeout", W'(ifa.AXIS_IN_TREADY), W'(1));
    @(posedge clk);
    #1;
    ifa.AXIS_IN_TVALID = 1'b0;
  endtask

  task automatic clear_logs();
    fd_log.delete();
    md_log.delete();
    fd_cyc.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    reset = 1'b1;
    ifa.AXIS_IN_TDATA = '0;  ifa.AXIS_IN_TVALID = 1'b0;
    ifa.AXIS_FD_OUT_TREADY = 1'b1; ifa.AXIS_MD_OUT_TREADY = 1'b1;
    ifb.AXIS_IN_TDATA = '0;  ifb.AXIS_IN_TVALID = 1'b0;
    ifb.AXIS_FD_OUT_TREADY = 1'b1; ifb.AXIS_MD_OUT_TREADY = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Back-to-back frames, both downstream ready
    clear_logs();
    for (int i = 0; i < 8; i++) send_a(W'('hD00 + i));
    repeat (3) tick();
    chk("t1_fd_count", W'(fd_log.size()), W'(8));
    for (int i = 0; i < 8 && i < fd_log.size(); i++) begin
      chk("t1_fd_order", fd_log[i], W'('hD00 + i));
      chk("t1_fd_no_bubble", W'(fd_cyc[i] - fd_cyc[0]), W'(i));
    end
    chk("t1_md_count", W'(md_log.size()), W'(2));
    for (int i = 0; i < 2 && i < md_log.size(); i++) begin
      chk("t1_md_frame_num", W'(md_log[i][31:0]), W'(i));
      chk("t1_md_span", W'(span(md_log[i])), W'(3));
    end
    chk("t1_frames_done", W'(done_a), W'(2));

    // MD held: last beat of next frame stalls until MD drains
    do_reset();
    clear_logs();
    ifa.AXIS_MD_OUT_TREADY = 1'b0;
    for (int i = 0; i < 7; i++) send_a(W'('hE00 + i));
    ifa.AXIS_IN_TDATA  = W'('hE07);
    ifa.AXIS_IN_TVALID = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2_stall_last", W'(ifa.AXIS_IN_TREADY), W'(0));
      chk("t2_md_held", W'(ifa.AXIS_MD_OUT_TVALID), W'(1));
      chk("t2_md_held_num", W'(ifa.AXIS_MD_OUT_TDATA[31:0]), W'(0));
      tick();
    end
    ifa.AXIS_MD_OUT_TREADY = 1'b1;
    @(negedge clk);
    chk("t2_release_ready", W'(ifa.AXIS_IN_TREADY), W'(1));
    tick();
    ifa.AXIS_MD_OUT_TREADY = 1'b0;
    ifa.AXIS_IN_TVALID     = 1'b0;
    @(negedge clk);
    chk("t2_md_reload", W'(ifa.AXIS_MD_OUT_TVALID), W'(1));
    chk("t2_md_num1", W'(ifa.AXIS_MD_OUT_TDATA[31:0]), W'(1));
    chk("t2_md_log0", W'(md_log.size()), W'(1));
    chk("t2_frames_done", W'(done_a), W'(1));
    tick();
    for (int i = 8; i < 11; i++) send_a(W'('hE00 + i));
    ifa.AXIS_MD_OUT_TREADY = 1'b1;
    send_a(W'('hE0B));
    repeat (4) tick();
    chk("t2_md_total", W'(md_log.size()), W'(3));
    if (md_log.size() == 3) chk("t2_md_num2", W'(md_log[2][31:0]), W'(2));
    chk("t2_fd_total", W'(fd_log.size()), W'(12));

    // FD_OUT_TREADY toggling 1010 with random input valid
    clear_logs();
    k = 0;
    ifa.AXIS_IN_TDATA = W'('hF00);
    for (int c = 0; c < 80; c++) begin
      ifa.AXIS_FD_OUT_TREADY = (c % 2 == 0);
      ifa.AXIS_IN_TVALID     = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (ifa.AXIS_IN_TVALID && ifa.AXIS_IN_TREADY) k++;
      tick();
      ifa.AXIS_IN_TDATA = W'('hF00 + k);
    end
    ifa.AXIS_IN_TVALID     = 1'b0;
    ifa.AXIS_FD_OUT_TREADY = 1'b1;
    repeat (3) tick();
    chk("t3_fd_count", W'(fd_log.size()), W'(k));
    for (int i = 0; i < fd_log.size(); i++) chk("t3_fd_order", fd_log[i], W'('hF00 + i));

    // Reset in the middle of a frame
    do_reset();
    clear_logs();
    for (int i = 0; i < 7; i++) send_a(W'('hA00 + i));
    tick();
    chk("t4_pre_done", W'(done_a), W'(1));
    ifa.AXIS_IN_TDATA  = W'('hA07);
    ifa.AXIS_IN_TVALID = 1'b1;
    #1;
    reset = 1'b1;
    #1;
    chk("t4_async_fd", W'(ifa.AXIS_FD_OUT_TVALID), W'(0));
    chk("t4_async_md", W'(ifa.AXIS_MD_OUT_TVALID), W'(0));
    chk("t4_async_ready", W'(ifa.AXIS_IN_TREADY), W'(0));
    chk("t4_async_done", W'(done_a), W'(0));
    ifa.AXIS_IN_TVALID = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();
    clear_logs();
    for (int i = 0; i < 3; i++) send_a(W'('hB00 + i));
    tick();
    chk("t4_no_early_md", W'(md_log.size() + ifa.AXIS_MD_OUT_TVALID), W'(0));
    send_a(W'('hB03));
    repeat (2) tick();
    chk("t4_md_count", W'(md_log.size()), W'(1));
    if (md_log.size() == 1) chk("t4_md_num0", W'(md_log[0][31:0]), W'(0));

    // One-beat frames on dut_b
    fdb_log.delete();
    mdb_log.delete();
    for (int i = 0; i < 3; i++) begin
      ifb.AXIS_IN_TDATA  = W'('hC00 + i);
      ifb.AXIS_IN_TVALID = 1'b1;
      @(negedge clk);
      chk("t5_ready", W'(ifb.AXIS_IN_TREADY), W'(1));
      tick();
    end
    ifb.AXIS_IN_TVALID = 1'b0;
    repeat (3) tick();
    chk("t5_md_count", W'(mdb_log.size()), W'(3));
    for (int i = 0; i < mdb_log.size(); i++) begin
      chk("t5_md_num", W'(mdb_log[i][31:0]), W'(i));
      chk("t5_md_span", W'(span(mdb_log[i])), W'(0));
    end
    for (int i = 0; i < fdb_log.size(); i++) chk("t5_fd_data", fdb_log[i], W'('hC00 + i));
    chk("t5_frames_done", W'(done_b), W'(3));

    // Wrap of frame_num and frames_done
    clear_logs();
    force dut_a.frame_num   = 32'hFFFF_FFFF;
    force dut_a.frames_done = 32'hFFFF_FFFF;
    force_req = 1;
    tick();
    release dut_a.frame_num;
    release dut_a.frames_done;
    @(negedge clk);
    chk("t6_done_forced", W'(done_a), W'(32'hFFFF_FFFF));
    tick();
    for (int i = 0; i < 4; i++) send_a(W'('h900 + i));
    repeat (2) tick();
    chk("t6_done_wrap", W'(done_a), W'(0));
    for (int i = 4; i < 8; i++) send_a(W'('h900 + i));
    repeat (2) tick();
    chk("t6_md_count", W'(md_log.size()), W'(2));
    if (md_log.size() == 2) begin
      chk("t6_md_num_max", W'(md_log[0][31:0]), W'(32'hFFFF_FFFF));
      chk("t6_md_num_wrap", W'(md_log[1][31:0]), W'(0));
    end
    chk("t6_done_after", W'(done_a), W'(1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
